// File: rtl/m3_speed_ramp_ctrl_if.sv
// -----------------------------------------------------------------------------
// m3_speed_ramp_ctrl_if
// Bundles the speed-command inputs and the ramp status outputs of
// m3_speed_ramp_ctrl.
//   master : drives the command inputs and observes the status outputs
//            (speed supervisor / testbench side)
//   slave  : the ramp controller itself
// Command inputs : workingI, nextRoundI, speedIncI, speedDecI, forceStopI,
//                  invRotateI (+ targetEnI, targetPeriodI when
//                  M3_RAMP_TARGET_EN is defined)
// Status outputs : periodO, dirO, stateO, atMinO, atMaxO, tickO
// Optional feature macro: M3_RAMP_TARGET_EN
// -----------------------------------------------------------------------------
interface m3_speed_ramp_ctrl_if #(
   parameter int PERIOD_W = 32
);
   logic                workingI;
   logic                nextRoundI;
   logic                speedIncI;
   logic                speedDecI;
   logic                forceStopI;
   logic                invRotateI;
`ifdef M3_RAMP_TARGET_EN
   logic                targetEnI;
   logic [PERIOD_W-1:0] targetPeriodI;
`endif
   logic [PERIOD_W-1:0] periodO;
   logic                dirO;
   logic [1:0]          stateO;
   logic                atMinO;
   logic                atMaxO;
   logic                tickO;

   modport master (
      output workingI, nextRoundI, speedIncI, speedDecI, forceStopI, invRotateI,
`ifdef M3_RAMP_TARGET_EN
      output targetEnI, targetPeriodI,
`endif
      input  periodO, dirO, stateO, atMinO, atMaxO, tickO
   );

   modport slave (
      input  workingI, nextRoundI, speedIncI, speedDecI, forceStopI, invRotateI,
`ifdef M3_RAMP_TARGET_EN
      input  targetEnI, targetPeriodI,
`endif
      output periodO, dirO, stateO, atMinO, atMaxO, tickO
   );
endinterface

// File: rtl/m3_speed_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// m3_speed_ramp_ctrl
// Speed-ramp controller for the 3-phase drive. Holds the commutation period
// and shortens/lengthens it by period>>STEP_SHIFT once every ROUND_MAX+1
// electrical rounds while INC/DEC is requested. A direction change first
// decelerates to PERIOD_MAX, then flips dirO and resumes. Also produces a
// one-cycle housekeeping tick every TICK_DIV cycles while working.
// Ports:
//   clkI  : system clock
//   nRstI : asynchronous active-low reset
//   bus   : m3_speed_ramp_ctrl_if.slave (command inputs, status outputs)
// Optional feature macro: M3_RAMP_TARGET_EN (target-period ramp mode)
// -----------------------------------------------------------------------------
module m3_speed_ramp_ctrl #(
   parameter int PERIOD_W    = 32,
   parameter int PERIOD_MAX  = 4000000,
   parameter int PERIOD_MIN  = 40,
   parameter int STEP_SHIFT  = 4,
   parameter int ROUND_CNT_W = 4,
   parameter int ROUND_MAX   = 3,
   parameter int TICK_DIV    = 10000
) (
   input  logic                 clkI,
   input  logic                 nRstI,
   m3_speed_ramp_ctrl_if.slave  bus
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PERIOD_W-1:0]    C_MAX       = PERIOD_W'(PERIOD_MAX);
   localparam logic [PERIOD_W-1:0]    C_MIN       = PERIOD_W'(PERIOD_MIN);
   localparam logic [PERIOD_W:0]      C_MAX_X     = (PERIOD_W+1)'(PERIOD_MAX);
   localparam logic [PERIOD_W:0]      C_MIN_X     = (PERIOD_W+1)'(PERIOD_MIN);
   localparam logic [ROUND_CNT_W-1:0] C_ROUND     = ROUND_CNT_W'(ROUND_MAX);
   localparam logic [TICK_W-1:0]      C_TICK_LOAD = TICK_W'(TICK_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_REV  = 2'd2
   } state_t;

   state_t                 r_state;
   logic [PERIOD_W-1:0]    r_period;
   logic                   r_dir;
   logic                   r_at_min;
   logic                   r_at_max;
   logic [ROUND_CNT_W-1:0] r_round_cnt;
   logic                   r_last_inc;   // 1 = last ramp mode was INC
   logic [TICK_W-1:0]      r_tick_cnt;
   logic                   r_tick;

   logic [PERIOD_W-1:0]    w_step_raw;
   logic [PERIOD_W-1:0]    w_step;
   logic [PERIOD_W-1:0]    w_step_eff;
   logic [PERIOD_W:0]      w_sub;
   logic [PERIOD_W:0]      w_add;
   logic [PERIOD_W-1:0]    w_shorter;    // faster: period - step, clamped
   logic [PERIOD_W-1:0]    w_longer;     // slower: period + step, clamped
   logic                   w_req_inc;
   logic                   w_req_dec;

   // Minimum step of 1 so the ramp never stalls at very short periods.
   assign w_step_raw = r_period >> STEP_SHIFT;
   assign w_step     = (w_step_raw == '0) ? PERIOD_W'(1) : w_step_raw;

`ifdef M3_RAMP_TARGET_EN
   logic [PERIOD_W-1:0] w_tgt;
   logic [PERIOD_W-1:0] w_dist;
   logic                w_tgt_mode;

   assign w_tgt      = (bus.targetPeriodI < C_MIN) ? C_MIN :
                       (bus.targetPeriodI > C_MAX) ? C_MAX : bus.targetPeriodI;
   assign w_dist     = (w_tgt > r_period) ? (w_tgt - r_period) : (r_period - w_tgt);
   // Target mode only shapes RUN; reversal deceleration keeps the full step.
   assign w_tgt_mode = bus.targetEnI && (r_state == ST_RUN);
   assign w_step_eff = (w_tgt_mode && (w_dist < w_step)) ? w_dist : w_step;
   assign w_req_inc  = w_tgt_mode ? (w_tgt < r_period) : bus.speedIncI;
   assign w_req_dec  = w_tgt_mode ? (w_tgt > r_period) : (!bus.speedIncI && bus.speedDecI);
`else
   assign w_step_eff = w_step;
   assign w_req_inc  = bus.speedIncI;
   assign w_req_dec  = !bus.speedIncI && bus.speedDecI;
`endif

   // One extra bit catches borrow/carry so results clamp instead of wrapping.
   assign w_sub     = {1'b0, r_period} - {1'b0, w_step_eff};
   assign w_add     = {1'b0, r_period} + {1'b0, w_step_eff};
   assign w_shorter = (w_sub[PERIOD_W] || (w_sub < C_MIN_X)) ? C_MIN : w_sub[PERIOD_W-1:0];
   assign w_longer  = (w_add > C_MAX_X) ? C_MAX : w_add[PERIOD_W-1:0];

   // Ramp / direction state machine. atMin/atMax are loaded alongside the
   // period so they match periodO in the same cycle.
   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         r_state     <= ST_IDLE;
         r_period    <= C_MAX;
         r_dir       <= 1'b0;
         r_at_min    <= 1'b0;
         r_at_max    <= 1'b1;
         r_round_cnt <= C_ROUND;
         r_last_inc  <= 1'b1;
      end else if (!bus.workingI || bus.forceStopI) begin
         r_state     <= ST_IDLE;
         r_period    <= C_MAX;
         r_at_min    <= (C_MAX == C_MIN);
         r_at_max    <= 1'b1;
         r_round_cnt <= C_ROUND;
         r_last_inc  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_RUN;
            end

            ST_RUN: begin
               if (bus.invRotateI != r_dir) begin
                  // Reversal wins over this cycle's round pulse.
                  r_state <= ST_REV;
               end else if (bus.nextRoundI) begin
                  if (w_req_inc) begin
                     if (!r_last_inc) begin
                        r_round_cnt <= C_ROUND;
                        r_last_inc  <= 1'b1;
                     end else if (r_round_cnt == '0) begin
                        r_round_cnt <= C_ROUND;
                        r_period    <= w_shorter;
                        r_at_min    <= (w_shorter == C_MIN);
                        r_at_max    <= (w_shorter == C_MAX);
                     end else begin
                        r_round_cnt <= r_round_cnt - 1'b1;
                     end
                  end else if (w_req_dec) begin
                     if (r_last_inc) begin
                        r_round_cnt <= C_ROUND;
                        r_last_inc  <= 1'b0;
                     end else if (r_round_cnt == '0) begin
                        r_round_cnt <= C_ROUND;
                        r_period    <= w_longer;
                        r_at_min    <= (w_longer == C_MIN);
                        r_at_max    <= (w_longer == C_MAX);
                     end else begin
                        r_round_cnt <= r_round_cnt - 1'b1;
                     end
                  end else begin
                     r_round_cnt <= C_ROUND;
                  end
               end
            end

            ST_REV: begin
               if (bus.invRotateI == r_dir) begin
                  // Reversal request withdrawn: resume at the current period.
                  r_state <= ST_RUN;
               end else if (r_period == C_MAX) begin
                  r_dir       <= ~r_dir;
                  r_round_cnt <= C_ROUND;
                  r_last_inc  <= 1'b1;
                  r_state     <= ST_RUN;
               end else if (bus.nextRoundI) begin
                  r_period <= w_longer;
                  r_at_min <= (w_longer == C_MIN);
                  r_at_max <= (w_longer == C_MAX);
               end
            end

            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Housekeeping tick: free-running while working, parked when not.
   always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
         r_tick_cnt <= C_TICK_LOAD;
         r_tick     <= 1'b0;
      end else if (!bus.workingI) begin
         r_tick_cnt <= C_TICK_LOAD;
         r_tick     <= 1'b0;
      end else if (r_tick_cnt == '0) begin
         r_tick_cnt <= C_TICK_LOAD;
         r_tick     <= 1'b1;
      end else begin
         r_tick_cnt <= r_tick_cnt - 1'b1;
         r_tick     <= 1'b0;
      end
   end

   assign bus.periodO = r_period;
   assign bus.dirO    = r_dir;
   assign bus.stateO  = r_state;
   assign bus.atMinO  = r_at_min;
   assign bus.atMaxO  = r_at_max;
   assign bus.tickO   = r_tick;

endmodule

// File: tb/tb_m3_speed_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// tb_m3_speed_ramp_ctrl
// Self-checking bench for m3_speed_ramp_ctrl (PERIOD_MAX=300, PERIOD_MIN=40,
// STEP_SHIFT=4, ROUND_MAX=3, TICK_DIV=10). Expected periods and tick times are
// pushed into scoreboards when stimulus is applied and popped on DUT output.
// Target-mode scenario compiles only with M3_RAMP_TARGET_EN.
// -----------------------------------------------------------------------------
module tb_m3_speed_ramp_ctrl;
   localparam int W    = 32;
   localparam int PMAX = 300;
   localparam int PMIN = 40;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   m3_speed_ramp_ctrl_if #(.PERIOD_W(W)) bus ();

   m3_speed_ramp_ctrl #(
      .PERIOD_W(W), .PERIOD_MAX(PMAX), .PERIOD_MIN(PMIN), .STEP_SHIFT(4),
      .ROUND_CNT_W(4), .ROUND_MAX(3), .TICK_DIV(10)
   ) dut (
      .clkI  (clk),
      .nRstI (rst_n),
      .bus   (bus.slave)
   );

   int n_pass  = 0;
   int n_total = 0;
   int exp_q[$];    // expected periodO after each round pulse
   int tick_q[$];   // expected cycle indices of tickO pulses

   function automatic int faster(input int p);
      int s;
      s = p / 16;
      if (s == 0) s = 1;
      return (p - s < PMIN) ? PMIN : p - s;
   endfunction

   task automatic step_clk();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse();
      bus.nextRoundI = 1'b1;
      step_clk();
      bus.nextRoundI = 1'b0;
   endtask

   task automatic do_reset();
      bus.workingI = 0; bus.nextRoundI = 0; bus.speedIncI = 0;
      bus.speedDecI = 0; bus.forceStopI = 0; bus.invRotateI = 0;
`ifdef M3_RAMP_TARGET_EN
      bus.targetEnI = 0; bus.targetPeriodI = '0;
`endif
      rst_n = 1'b0;
      step_clk();
      step_clk();
      rst_n = 1'b1;
      step_clk();
   endtask

   // Reset, enable and ramp 300 -> 282 with four INC rounds.
   task automatic go_to_282();
      do_reset();
      bus.workingI = 1'b1;
      step_clk();
      bus.speedIncI = 1'b1;
      repeat (4) pulse();
      bus.speedIncI = 1'b0;
      n_total++;
      if (bus.periodO !== 32'd282)
         $display("FAIL setup_282: periodO=%0d expected 282", bus.periodO);
      else n_pass++;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if (bus.periodO !== 32'd300) $display("FAIL reset_period: got %0d expected 300", bus.periodO);
      else n_pass++;
      n_total++;
      if ({bus.dirO, bus.stateO} !== 3'b0_00)
         $display("FAIL reset_dir_state: got %b expected 000", {bus.dirO, bus.stateO});
      else n_pass++;
      n_total++;
      if ({bus.atMaxO, bus.atMinO, bus.tickO} !== 3'b100)
         $display("FAIL reset_flags: max/min/tick got %b expected 100", {bus.atMaxO, bus.atMinO, bus.tickO});
      else n_pass++;
      bus.workingI = 1'b1;
      step_clk();
      n_total++;
      if (bus.stateO !== 2'd1) $display("FAIL reset_to_run: stateO=%0d expected 1", bus.stateO);
      else n_pass++;
      $display("reset: period=%0d state=%0d", bus.periodO, bus.stateO);
   endtask

   task automatic test_inc_to_min();
      int p;
      int e;
      p = PMAX;
      bus.speedIncI = 1'b1;
      for (int k = 1; k <= 160; k++) begin
         if (k % 4 == 0) p = faster(p);
         exp_q.push_back(p);
         pulse();
         e = exp_q.pop_front();
         $display("inc pulse %0d: period=%0d", k, bus.periodO);
         n_total++;
         if (bus.periodO !== 32'(e))
            $display("FAIL inc_period: pulse %0d got %0d expected %0d", k, bus.periodO, e);
         else n_pass++;
      end
      bus.speedIncI = 1'b0;
      n_total++;
      if ({bus.atMinO, bus.atMaxO} !== 2'b10)
         $display("FAIL inc_at_min: min/max got %b expected 10", {bus.atMinO, bus.atMaxO});
      else n_pass++;
   endtask

   task automatic test_dec_to_max();
      int tbl[9] = '{282, 282, 282, 282, 299, 299, 299, 299, 300};
      int e;
      go_to_282();
      bus.speedDecI = 1'b1;
      for (int k = 0; k < 9; k++) begin
         exp_q.push_back(tbl[k]);
         pulse();
         e = exp_q.pop_front();
         $display("dec pulse %0d: period=%0d", k + 1, bus.periodO);
         n_total++;
         if (bus.periodO !== 32'(e))
            $display("FAIL dec_period: pulse %0d got %0d expected %0d", k + 1, bus.periodO, e);
         else n_pass++;
      end
      bus.speedDecI = 1'b0;
      n_total++;
      if ({bus.atMaxO, bus.atMinO} !== 2'b10)
         $display("FAIL dec_at_max: max/min got %b expected 10", {bus.atMaxO, bus.atMinO});
      else n_pass++;
   endtask

   task automatic test_reversal();
      int tbl[2] = '{299, 300};
      int e;
      go_to_282();
      bus.speedIncI  = 1'b1;   // must be ignored while decelerating
      bus.invRotateI = 1'b1;
      step_clk();
      n_total++;
      if (bus.stateO !== 2'd2) $display("FAIL rev_enter: stateO=%0d expected 2", bus.stateO);
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back(tbl[k]);
         pulse();
         e = exp_q.pop_front();
         $display("rev pulse %0d: period=%0d state=%0d", k + 1, bus.periodO, bus.stateO);
         n_total++;
         if (bus.periodO !== 32'(e))
            $display("FAIL rev_period: pulse %0d got %0d expected %0d", k + 1, bus.periodO, e);
         else n_pass++;
      end
      step_clk();
      n_total++;
      if ({bus.dirO, bus.stateO} !== 3'b1_01)
         $display("FAIL rev_flip: dir/state got %b expected 101", {bus.dirO, bus.stateO});
      else n_pass++;
      bus.speedIncI = 1'b0;
   endtask

   task automatic test_force_stop_tick();
      int e;
      bit saw_tick;
      go_to_282();
      bus.invRotateI = 1'b1;
      step_clk();
      exp_q.push_back(299);
      pulse();
      e = exp_q.pop_front();
      n_total++;
      if (bus.periodO !== 32'(e)) $display("FAIL stop_pre: period got %0d expected %0d", bus.periodO, e);
      else n_pass++;
      bus.forceStopI = 1'b1;
      step_clk();
      $display("force stop: state=%0d period=%0d dir=%0d", bus.stateO, bus.periodO, bus.dirO);
      n_total++;
      if ({bus.stateO, bus.dirO} !== 3'b00_0)
         $display("FAIL stop_state_dir: got %b expected 000", {bus.stateO, bus.dirO});
      else n_pass++;
      n_total++;
      if (bus.periodO !== 32'd300) $display("FAIL stop_period: got %0d expected 300", bus.periodO);
      else n_pass++;
      bus.forceStopI = 1'b0;
      bus.invRotateI = 1'b0;
      bus.workingI   = 1'b0;
      saw_tick = 1'b0;
      for (int k = 0; k < 15; k++) begin
         step_clk();
         if (bus.tickO !== 1'b0) saw_tick = 1'b1;
      end
      n_total++;
      if (saw_tick) $display("FAIL tick_idle: tickO seen high while not working, expected 0");
      else n_pass++;
      bus.workingI = 1'b1;
      tick_q.push_back(10);
      tick_q.push_back(20);
      tick_q.push_back(30);
      for (int k = 1; k <= 35; k++) begin
         step_clk();
         if (bus.tickO === 1'b1) begin
            n_total++;
            if (tick_q.size() == 0) begin
               $display("FAIL tick_time: unexpected tick at cycle %0d, expected none", k);
            end else begin
               e = tick_q.pop_front();
               $display("tick at cycle %0d", k);
               if (k != e) $display("FAIL tick_time: tick at cycle %0d expected %0d", k, e);
               else n_pass++;
            end
         end
      end
      n_total++;
      if (tick_q.size() != 0) $display("FAIL tick_missing: %0d ticks missing, expected 0", tick_q.size());
      else n_pass++;
   endtask

   task automatic test_async_reset();
      go_to_282();
      bus.speedDecI = 1'b1;
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      $display("async reset: period=%0d state=%0d", bus.periodO, bus.stateO);
      n_total++;
      if ({bus.periodO, bus.stateO} !== {32'd300, 2'd0})
         $display("FAIL async_reset: period/state got %0d/%0d expected 300/0", bus.periodO, bus.stateO);
      else n_pass++;
      step_clk();
      rst_n = 1'b1;
      bus.speedDecI = 1'b0;
   endtask

`ifdef M3_RAMP_TARGET_EN
   task automatic test_target();
      int tbl[8] = '{300, 300, 300, 290, 290, 290, 290, 290};
      int e;
      do_reset();
      bus.workingI = 1'b1;
      step_clk();
      bus.targetEnI     = 1'b1;
      bus.targetPeriodI = 32'd290;
      bus.speedDecI     = 1'b1;   // ignored in target mode
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(tbl[k]);
         pulse();
         e = exp_q.pop_front();
         $display("target pulse %0d: period=%0d", k + 1, bus.periodO);
         n_total++;
         if (bus.periodO !== 32'(e))
            $display("FAIL target_period: pulse %0d got %0d expected %0d", k + 1, bus.periodO, e);
         else n_pass++;
      end
      bus.targetEnI = 1'b0;
      bus.speedDecI = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_inc_to_min();
      test_dec_to_max();
      test_reversal();
      test_force_stop_tick();
      test_async_reset();
`ifdef M3_RAMP_TARGET_EN
      test_target();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/m3_speed_ramp_ctrl.md
Name: m3_speed_ramp_ctrl

Overview:
- Parametrised speed-ramp controller for the 3-phase motor drive. Sits between the speed command inputs and the commutation timer.
- Keeps the commutation period; shortens or lengthens it by 1/2^STEP_SHIFT once every ROUND_MAX+1 rounds while INC or DEC is held.
- Handles direction reversal safely: decelerates to PERIOD_MAX, flips direction, then resumes.
- Also generates a one-cycle housekeeping tick.

Parameters:
- PERIOD_W, 32, width of period register and output
- PERIOD_MAX, 4000000, slowest period (clk cycles)
- PERIOD_MIN, 40, fastest period (clk cycles)
- STEP_SHIFT, 4, ramp step = period >> STEP_SHIFT
- ROUND_CNT_W, 4, width of the round hysteresis counter
- ROUND_MAX, 3, rounds per step minus 1
- TICK_DIV, 10000, tick interval in clk cycles

Ports:
- clkI, in, 1, system clock
- nRstI, in, 1, asynchronous active-low reset
- workingI, in, 1, drive enabled; 0 forces IDLE
- nextRoundI, in, 1, one-cycle pulse per electrical round
- speedIncI, in, 1, request faster (priority over DEC)
- speedDecI, in, 1, request slower
- forceStopI, in, 1, immediate stop
- invRotateI, in, 1, requested direction level
- periodO, out, PERIOD_W, current commutation period
- dirO, out, 1, applied direction
- stateO, out, 2, 0=IDLE 1=RUN 2=REV_DECEL
- atMinO, out, 1, periodO==PERIOD_MIN
- atMaxO, out, 1, periodO==PERIOD_MAX
- tickO, out, 1, one-cycle pulse every TICK_DIV cycles while working

Behaviour:
- Reset values: periodO=PERIOD_MAX; dirO=0; stateO=IDLE; atMaxO=1; atMinO=0; tickO=0; roundCnt=ROUND_MAX; lastMode=INC; tick counter=TICK_DIV-1.
- step = periodO>>STEP_SHIFT, forced to 1 if zero.
- Add/subtract is done in PERIOD_W+1 bits. Results clamp to [PERIOD_MIN, PERIOD_MAX] with no wrap.
- Priority, highest first: workingI=0 or forceStopI=1, then reversal, then INC, then DEC.
- IDLE:
  - periodO=PERIOD_MAX, roundCnt=ROUND_MAX, lastMode=INC.
  - dirO is held.
  - Goes to RUN on the first cycle with workingI=1 and forceStopI=0.
- Any state with workingI=0 or forceStopI=1: next cycle is IDLE with the IDLE values loaded; dirO unchanged.
- RUN: acts only on nextRoundI=1.
  - speedIncI=1, lastMode=INC: if roundCnt==0, reload ROUND_MAX and periodO=max(periodO-step, PERIOD_MIN); else roundCnt-1.
  - speedIncI=1, lastMode=DEC: reload roundCnt, lastMode=INC, no period change.
  - speedDecI=1 (INC low): mirror image; periodO=min(periodO+step, PERIOD_MAX).
  - Neither set: reload roundCnt; lastMode unchanged.
- RUN to REV_DECEL: when invRotateI!=dirO, checked every cycle. Transition is next cycle; the same cycle's nextRoundI is ignored.
- REV_DECEL:
  - Each nextRoundI: periodO=min(periodO+step, PERIOD_MAX). No round hysteresis; INC/DEC ignored.
  - When periodO==PERIOD_MAX, or on entry already at max: next cycle toggles dirO, reloads roundCnt, sets lastMode=INC, returns to RUN.
  - If invRotateI returns equal to dirO before that: back to RUN, periodO kept, no toggle.
- atMinO/atMaxO are registered and track periodO in the same cycle it updates.
- Tick counter:
  - Held at TICK_DIV-1 while workingI=0; otherwise counts down.
  - At 0: tickO=1 for that cycle, then reloads. Independent of forceStopI.
- Reset asserted mid-operation returns all state to reset values asynchronously.

Optional Feature:
- Macro: M3_RAMP_TARGET_EN.
- Defined: adds inputs targetEnI (1) and targetPeriodI (PERIOD_W).
  - In RUN with targetEnI=1, INC/DEC inputs are ignored.
  - Direction is derived each nextRoundI: target<periodO acts as INC, target>periodO as DEC. Round hysteresis applies as normal.
  - Step is limited to |periodO-target|, so periodO lands exactly on the target. Equal means no change and roundCnt reloads.
  - Target is clamped to [PERIOD_MIN, PERIOD_MAX] before use.
- Undefined: the ports are absent and behaviour is exactly as above.

Test Plan:
All scenarios use PERIOD_MAX=300, PERIOD_MIN=40, STEP_SHIFT=4, ROUND_MAX=3, TICK_DIV=10.
- Reset then release: periodO=300, dirO=0, stateO=0, atMaxO=1, tickO=0. workingI=1 gives stateO=1 next cycle.
- speedIncI held, 4 nextRoundI pulses: periodO 300→282 on the 4th pulse only. Continuing gives strictly decreasing periods clamped at 40 with atMinO=1, never below 40.
- From 282, speedDecI held: 1st pulse only switches mode. The 5th pulse gives 282+17=299. Four more pulses give 317, clamped to 300, atMaxO=1.
- Reversal from 282, invRotateI=1: stateO=2, pulses give 299 then 300. The next cycle gives dirO=1, stateO=1. INC during REV_DECEL has no effect.
- forceStopI during REV_DECEL at 299: next cycle stateO=0, periodO=300, dirO=0 kept. workingI=0 holds tickO=0. Resuming gives the first tickO 10 cycles later, then every 10 cycles.
- M3_RAMP_TARGET_EN, targetEnI=1, targetPeriodI=290, period 300: after 4 pulses periodO=290 exactly (step limited from 18 to 10), then stays at 290.
